// File: rtl/paralelo_serial_tx_pkg.sv
// Shared PHY definitions for the serial lane.
// Holds the comma/idle symbol, the byte width on the wire and the
// TRAIN/ACTIVE state encoding. The transmit serializer uses them, and the
// lane receive deserializer can reuse them so both ends agree on the symbols.
package paralelo_serial_tx_pkg;

  // Comma symbol, sent both as the training pattern and as the idle filler.
  localparam logic [7:0] PHY_COMMA = 8'hBC;

  // Number of serial bit-times in one byte slot.
  localparam int BITS_PER_BYTE = 8;

  // Link phase: TRAIN sends only commas; ACTIVE accepts payload.
  typedef enum logic {
    TRAIN  = 1'b0,
    ACTIVE = 1'b1
  } phyState_e;

endpackage

// File: rtl/paralelo_serial_tx.sv
// Transmit-side byte serializer.
// After reset it sends TRAIN_COMMAS comma bytes so the receiver can lock,
// then enters ACTIVE. In ACTIVE it offers one byte slot every 8 bit-times:
// a byte presented with valid_in on the ready_out cycle is shifted out
// MSB-first. A slot with no payload carries a comma, which keeps the
// receiver byte-aligned.
//
// Ports:
//   clk_32f         in   bit clock, one serial bit per cycle
//   reset           in   asynchronous active-high reset
//   data_in[7:0]    in   payload byte, taken on a load edge when ready_out && valid_in
//   valid_in        in   data_in holds a byte to send
//   data_out        out  registered serial bit, MSB first
//   ready_out       out  one cycle in 8 while ACTIVE; the cycle in which data_in is taken
//   active_out      out  high while the link is ACTIVE
//   comma_collision out  one-cycle pulse after a payload byte equal to COMMA is accepted
module paralelo_serial_tx
  import paralelo_serial_tx_pkg::*;
#(
  // Commas sent after reset before payload is accepted. Legal range is 1..15.
  parameter int unsigned TRAIN_COMMAS = 4,
  parameter logic [7:0]  COMMA        = PHY_COMMA
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       data_out,
  output logic       ready_out,
  output logic       active_out,
  output logic       comma_collision
);

  localparam logic [2:0] LAST_BIT   = 3'(BITS_PER_BYTE - 1);
  localparam logic [3:0] LAST_COMMA = 4'(TRAIN_COMMAS - 1);

  phyState_e  state_q,     state_d;
  logic [2:0] bitCnt_q,    bitCnt_d;
  logic [6:0] shifter_q,   shifter_d;
  logic [3:0] commaCnt_q,  commaCnt_d;
  logic       dataOut_q,   dataOut_d;
  logic       collision_q, collision_d;

  logic       loadEdge;
  logic       acceptPayload;
  logic [7:0] nextByte;

  // A load edge is the clock edge that closes bit 0 of the current byte and
  // launches the next one. The counter sits at 7 out of reset, so the very
  // first edge after release already starts a byte.
  assign loadEdge      = (bitCnt_q == LAST_BIT);
  assign acceptPayload = (state_q == ACTIVE) && valid_in;
  assign nextByte      = acceptPayload ? data_in : COMMA;

  // Next-state logic for the shifter, bit counter and link FSM.
  // Bit 7 of a new byte goes straight to the output register, so the shifter
  // only needs to hold the remaining seven bits. In TRAIN every slot carries
  // a comma; the slot that sends the last training comma also switches the
  // link to ACTIVE, so the very next slot is already open for payload.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shifter_d   = shifter_q;
    commaCnt_d  = commaCnt_q;
    dataOut_d   = dataOut_q;
    collision_d = 1'b0;

    if (loadEdge) begin
      shifter_d   = nextByte[6:0];
      dataOut_d   = nextByte[7];
      bitCnt_d    = 3'd0;
      collision_d = acceptPayload && (data_in == COMMA);
      if (state_q == TRAIN) begin
        commaCnt_d = commaCnt_q + 4'd1;
        if (commaCnt_q == LAST_COMMA) begin
          state_d = ACTIVE;
        end
      end
    end else begin
      dataOut_d = shifter_q[6];
      shifter_d = {shifter_q[5:0], 1'b0};
      bitCnt_d  = bitCnt_q + 3'd1;
    end
  end

  // State registers. Reset drops any byte in flight and restarts training
  // from the first comma.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q     <= TRAIN;
      bitCnt_q    <= LAST_BIT;
      shifter_q   <= '0;
      commaCnt_q  <= '0;
      dataOut_q   <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shifter_q   <= shifter_d;
      commaCnt_q  <= commaCnt_d;
      dataOut_q   <= dataOut_d;
      collision_q <= collision_d;
    end
  end

  // ready_out is decoded from registers only, so upstream never sees a
  // combinational path from its own valid_in/data_in.
  assign data_out        = dataOut_q;
  assign ready_out       = (state_q == ACTIVE) && (bitCnt_q == LAST_BIT);
  assign active_out      = (state_q == ACTIVE);
  assign comma_collision = collision_q;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Self-checking bench for paralelo_serial_tx.
// The driver decides each byte slot's content from the link rules (slot
// index since reset, training length, valid at the load edge) and queues the
// expected byte and collision flag. An independent monitor rebuilds bytes
// from the serial line and compares them against the queue. A second
// instance with TRAIN_COMMAS=1 is checked alongside it.
module tb_paralelo_serial_tx;

  localparam int         TC0      = 4;
  localparam int         TC1      = 1;
  localparam logic [7:0] COMMA_TB = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       data_out, ready_out, active_out, comma_collision;

  logic [7:0] idleData  = 8'h00;
  logic       idleValid = 1'b0;
  logic       data_out1, ready_out1, active_out1, comma_collision1;

  int         cyc;
  int         checks = 0;
  int         errors = 0;

  logic [7:0] expByteQ[$];
  bit         expCollQ[$];
  logic [7:0] directQ[$];
  logic [7:0] rxAcc;
  logic [7:0] commaVar = COMMA_TB;

  paralelo_serial_tx #(.TRAIN_COMMAS(TC0)) dut (
    .clk_32f        (clk_32f),
    .reset          (reset),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .data_out       (data_out),
    .ready_out      (ready_out),
    .active_out     (active_out),
    .comma_collision(comma_collision)
  );

  paralelo_serial_tx #(.TRAIN_COMMAS(TC1)) dut1 (
    .clk_32f        (clk_32f),
    .reset          (reset),
    .data_in        (idleData),
    .valid_in       (idleValid),
    .data_out       (data_out1),
    .ready_out      (ready_out1),
    .active_out     (active_out1),
    .comma_collision(comma_collision1)
  );

  // Free-running bit clock.
  always #5 clk_32f = ~clk_32f;

  // Edge count since reset release: after edge n the counter reads n.
  always @(posedge clk_32f or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Ready is expected in the cycle before each load edge once the training
  // commas have all been launched.
  function automatic bit expReady(input int n, input int tc);
    return (n % 8 == 0) && (n / 8 >= tc);
  endfunction

  // Active from the load edge that launches the last training comma.
  function automatic bit expActive(input int n, input int tc);
    return n >= 8 * (tc - 1) + 1;
  endfunction

  // Single comparison point; every check and every failure is counted here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Drive nCycles of stimulus starting just after a clock edge.
  // mode 0: valid never asserted. mode 1: random valid and data, sometimes
  // a comma as payload. mode 2: pop directQ on each open slot.
  // Between load edges valid/data are scrambled in modes 1/2 to show they
  // are ignored without ready.
  task automatic applyStimulus(input int nCycles, input int mode);
    int         n;
    bit         open;
    bit         v;
    logic [7:0] d;
    for (int i = 0; i < nCycles; i++) begin
      n = cyc;
      if (n % 8 == 0) begin
        open = (n / 8) >= TC0;
        v    = 1'b0;
        d    = 8'($urandom);
        if (mode == 1) begin
          v = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 5) == 0) d = COMMA_TB;
        end else if (mode == 2 && open && directQ.size() > 0) begin
          v = 1'b1;
          d = directQ.pop_front();
        end
        valid_in = v;
        data_in  = d;
        if (open && v) begin
          expByteQ.push_back(d);
          expCollQ.push_back(d == COMMA_TB);
        end else begin
          expByteQ.push_back(COMMA_TB);
          expCollQ.push_back(1'b0);
        end
      end else begin
        valid_in = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        data_in  = 8'($urandom);
      end
      @(posedge clk_32f);
      #2;
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk_32f) begin
    if (reset) begin
      checkOutput("rstDataOut",   data_out,        0);
      checkOutput("rstReady",     ready_out,       0);
      checkOutput("rstActive",    active_out,      0);
      checkOutput("rstCollision", comma_collision, 0);
      checkOutput("rstActive1",   active_out1,     0);
      expByteQ.delete();
      expCollQ.delete();
      rxAcc = 8'h00;
    end else begin
      checkOutput("readyOut",   ready_out,   expReady(cyc, TC0));
      checkOutput("activeOut",  active_out,  expActive(cyc, TC0));
      checkOutput("readyOut1",  ready_out1,  expReady(cyc, TC1));
      checkOutput("activeOut1", active_out1, expActive(cyc, TC1));
      if (cyc >= 1) begin
        checkOutput("idleBit1", data_out1, commaVar[3'(7 - (cyc - 1) % 8)]);
        rxAcc = {rxAcc[6:0], data_out};
        if ((cyc - 1) % 8 == 7) begin
          if (expByteQ.size() == 0) checkOutput("byteQueueEmpty", 1, 0);
          else checkOutput("serialByte", rxAcc, expByteQ.pop_front());
        end
        if (cyc % 8 == 1) begin
          if (expCollQ.size() == 0) checkOutput("collQueueEmpty", 1, 0);
          else checkOutput("commaCollision", comma_collision, expCollQ.pop_front());
        end else begin
          checkOutput("collisionQuiet", comma_collision, 0);
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(posedge clk_32f);
    #2;
    reset = 1'b0;

    // Training then idle filler with no payload.
    applyStimulus(8 * 8, 0);

    // Single payload byte followed by an idle slot.
    directQ = '{8'hA5};
    applyStimulus(16, 2);

    // Back-to-back payload with no idle gap.
    directQ = '{8'h01, 8'h02, 8'h03};
    applyStimulus(24, 2);

    // Payload equal to the comma symbol.
    directQ = '{8'hBC};
    applyStimulus(16, 2);

    // Random traffic.
    applyStimulus(8 * 40, 1);

    // Reset in the middle of a payload byte while bit 3 is on the line.
    directQ = '{8'hFF};
    applyStimulus(5, 2);
    checkOutput("preResetBit", data_out, 1);
    reset = 1'b1;
    #1;
    checkOutput("midRstDataOut", data_out,   0);
    checkOutput("midRstActive",  active_out, 0);
    @(posedge clk_32f);
    #2;
    reset = 1'b0;

    // Training must restart; random valid during training must be ignored.
    applyStimulus(8 * 8, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/paralelo_serial_tx.md
Name: paralelo_serial_tx

Overview:
Transmit-side serializer that feeds the lane receive deserializer. It accepts bytes on a ready/valid strobe once every 8 bit-times and shifts them out MSB-first on a single bit line. After reset it sends a fixed run of 8'hBC comma training bytes. In the active phase it fills every byte slot with no accepted payload with 8'hBC idle, so the receiver always holds byte alignment.

Parameters:
TRAIN_COMMAS, 4, number of 8'hBC bytes sent after reset before payload is accepted; legal range is 1 to 15. The default satisfies the receiver's 3-comma lock plus 1 activation byte.
COMMA, 8'hBC, comma/idle symbol.

Ports:
clk_32f  input  1  bit clock, one serial bit per cycle.
reset  input  1  asynchronous, active-high reset.
data_in  input  8  payload byte, sampled only on a load edge when ready_out and valid_in are both high.
valid_in  input  1  data_in holds a byte to send.
data_out  output  1  serial bit, registered, MSB of each byte first.
ready_out  output  1  high for one cycle in 8 while ACTIVE; marks the cycle in which data_in is accepted.
active_out  output  1  high while state is ACTIVE.
comma_collision  output  1  one-cycle pulse when an accepted payload byte equals COMMA.

Behaviour:
- Reset values (asynchronous, while reset=1):
  - data_out=0, ready_out=0, active_out=0, comma_collision=0.
  - State TRAIN, bit_cnt=7, shifter=0, comma_cnt=0.
- bit_cnt is 3 bits and wraps 7->0. A "load edge" is any clk_32f rising edge with bit_cnt==7.
  - bit_cnt=7 at reset, so the first edge after reset release is a load edge.
  - Load edges therefore fall at edges 1, 9, 17, ... after release.
- On a load edge:
  - Select the byte: if state==ACTIVE and valid_in==1, take data_in; otherwise take COMMA.
  - shifter<=byte, data_out<=byte[7], bit_cnt<=0.
- On a non-load edge: data_out<=shifter[6], shifter<=shifter<<1, bit_cnt<=bit_cnt+1.
- Latency: a byte accepted at load edge E drives its bit 7 on data_out from E to E+1, and its bit 0 from E+7 to E+8.
- ready_out = (state==ACTIVE && bit_cnt==7), decoded from registers only. It has no combinational path from valid_in or data_in.
- valid_in without ready_out is ignored and not stored. The upstream block must hold data_in/valid_in until it sees ready_out.
- State machine:
  - TRAIN: each load edge sends COMMA and increments comma_cnt (valid_in ignored). On the load edge that sends comma number TRAIN_COMMAS, go to ACTIVE.
  - ACTIVE: stays ACTIVE until reset; there is no return to TRAIN.
  - active_out=1 from that load edge onward.
- Idle insertion: in ACTIVE, a load edge with valid_in=0 sends COMMA. This is not an error.
- comma_collision: registered. It is high for the cycle after a load edge that accepted data_in==COMMA with valid_in=1. The byte is still transmitted, although the receiver will flag it invalid.
- Reset mid-byte: outputs go to reset values at once; the partial byte is dropped. After release, training restarts from comma 1.
- Reset asserted for exactly one cycle has the same effect as a longer reset.

Decomposition:
- Shared PHY package holds COMMA=8'hBC, the TRAIN/ACTIVE state encoding, and BITS_PER_BYTE=8 for reuse by the receiver.
- No sub-module is needed. The shifter, counter and FSM stay in one module.

Test Plan:
- Reset release with valid_in=0: data_out carries 10111100 repeated from edge 1; active_out rises at edge 25; ready_out is first high between edges 32 and 33.
- Payload 8'hA5 held with valid_in=1 from edge 30: accepted at edge 33; data_out over edges 33..40 is 1,0,1,0,0,1,0,1; the next slot is COMMA if valid_in is then dropped.
- Back-to-back 8'h01, 8'h02, 8'h03 each presented on their ready_out cycles: three consecutive bytes with no idle gap; loopback into the receiver yields valid_out=1 with the same byte sequence.
- valid_in=1 with data_in=8'hBC at an ACTIVE load edge: 10111100 is transmitted; comma_collision pulses for exactly one cycle; active_out stays 1.
- reset asserted at bit 3 of a payload byte: data_out=0 and active_out=0 immediately; after release, 4 commas are sent before ready_out reappears.
- TRAIN_COMMAS=1: active_out rises at edge 1; ready_out is first high between edges 8 and 9.
